inv_mixcolumns_iter: RTL and testbench



---
 rtl/inv_mixcolumns_iter_pkg.sv | 35 +++
 rtl/inv_mixcolumns_iter_if.sv | 22 ++
 rtl/inv_mixcolumns_iter_column.sv | 18 +
 rtl/inv_mixcolumns_iter.sv | 103 ++++++++++
 tb/tb_inv_mixcolumns_iter.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inv_mixcolumns_iter_pkg.sv
// Shared AES GF(2^8) helpers and types for the inverse MixColumns datapath.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef logic [31:0]  col_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } imc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ x;
    endfunction

    function automatic logic [7:0] gmulb(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
    endfunction

    function automatic logic [7:0] gmuld(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
    endfunction

    function automatic logic [7:0] gmule(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
    endfunction

endpackage

// File: rtl/inv_mixcolumns_iter_if.sv
// Input and output valid/ready streams of the inverse MixColumns unit.
interface inv_mixcolumns_iter_if;
    import aes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t in_data;
    logic   out_valid;
    logic   out_ready;
    state_t out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/inv_mixcolumns_iter_column.sv
// Combinational InvMixColumns of a single 32-bit column, row 0 in the MS byte.
module inv_mix_column
    import aes_pkg::*;
(
    input  col_t col_i,
    output col_t col_o
);

    logic [7:0] s0, s1, s2, s3;

    assign {s0, s1, s2, s3} = col_i;

    assign col_o[31:24] = gmule(s0) ^ gmulb(s1) ^ gmuld(s2) ^ gmul9(s3);
    assign col_o[23:16] = gmul9(s0) ^ gmule(s1) ^ gmulb(s2) ^ gmuld(s3);
    assign col_o[15:8]  = gmuld(s0) ^ gmul9(s1) ^ gmule(s2) ^ gmulb(s3);
    assign col_o[7:0]   = gmulb(s0) ^ gmuld(s1) ^ gmul9(s2) ^ gmule(s3);

endmodule

// File: rtl/inv_mixcolumns_iter.sv
// Iterative AES InvMixColumns: one state in, COLS_PER_CYCLE columns per clock, registered result out.
module inv_mixcolumns_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    inv_mixcolumns_iter_if.slave bus
);

    localparam int NCYC  = 4 / COLS_PER_CYCLE;
    localparam int CNT_W = $clog2(NCYC) + 1;

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
        $error("inv_mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    imc_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    state_t           work_q;
    state_t           work_d;
    logic             out_valid_q;
    logic             accept;
    col_t             col_in  [COLS_PER_CYCLE];
    col_t             col_out [COLS_PER_CYCLE];

    // The pending result may be handed off and a new block taken on the same edge.
    assign bus.in_ready  = !rst && (state_q == IDLE || (state_q == DONE && bus.out_ready));
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = work_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            col_in[k] = '0;
        end
        for (int c = 0; c < 4; c++) begin
            if (c / COLS_PER_CYCLE == int'(cnt_q)) begin
                col_in[c % COLS_PER_CYCLE] = work_q[127 - 32*c -: 32];
            end
        end
    end

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        inv_mix_column u_col (
            .col_i (col_in[k]),
            .col_o (col_out[k])
        );
    end

    always_comb begin
        work_d = work_q;
        for (int c = 0; c < 4; c++) begin
            if (c / COLS_PER_CYCLE == int'(cnt_q)) begin
                work_d[127 - 32*c -: 32] = col_out[c % COLS_PER_CYCLE];
            end
        end
    end

    // NOTE: the working register is cleared on reset because it drives out_data directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        work_q  <= bus.in_data;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NCYC - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (accept) begin
                            work_q  <= bus.in_data;
                            cnt_q   <= '0;
                            state_q <= BUSY;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_mixcolumns_iter.sv
// Self-checking bench for inv_mixcolumns_iter against a matrix-form GF(2^8) model.
module tb_inv_mixcolumns_iter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    inv_mixcolumns_iter_if bus1 ();
    inv_mixcolumns_iter_if bus2 ();
    inv_mixcolumns_iter_if bus4 ();

    inv_mixcolumns_iter #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    inv_mixcolumns_iter #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    inv_mixcolumns_iter #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Generic carry-less multiply followed by reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    // Circulant matrix product per column; row r uses the first row rotated right by r.
    function automatic logic [127:0] mix(input logic [127:0] s, input bit inverse);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (inverse) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = '0;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gf_mul(coef[(k - row + 4) % 4], s[127 - 32*c - 8*k -: 8]);
                end
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Scoreboard: blocks in flight with their accept cycle.
    logic [127:0] exp_q [$];
    int           acc_q [$];
    bit           prev_valid = 1'b0;
    bit           prev_ready = 1'b0;
    bit           past_rst   = 1'b0;

    always @(negedge clk) begin
        if (past_rst) begin
            check("reset_out_valid", 128'(bus1.out_valid), 128'(0));
            check("reset_out_data", bus1.out_data, 128'(0));
        end
        if (rst) begin
            check("rst_in_ready", 128'(bus1.in_ready), 128'(0));
        end else begin
            if (exp_q.size() == 0) begin
                check("idle_out_valid", 128'(bus1.out_valid), 128'(0));
                check("idle_in_ready", 128'(bus1.in_ready), 128'(1));
            end else if (bus1.out_valid) begin
                check("out_data", bus1.out_data, exp_q[0]);
                check("done_in_ready", 128'(bus1.in_ready), 128'(bus1.out_ready));
                if (!prev_valid) check_i("latency", cyc - acc_q[0], 4);
                if (bus1.out_ready) begin
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                end
            end else begin
                check("busy_in_ready", 128'(bus1.in_ready), 128'(0));
                if (prev_valid && !prev_ready) check("valid_hold", 128'(bus1.out_valid), 128'(1));
            end
            if (bus1.in_valid && bus1.in_ready) begin
                exp_q.push_back(mix(bus1.in_data, 1'b1));
                acc_q.push_back(cyc + 1);
            end
        end
        prev_valid = !rst && bus1.out_valid;
        prev_ready = bus1.out_ready;
        past_rst   = rst;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
        end
    end

    // Round-trip checker active during the random stream.
    bit           streaming = 1'b0;
    bit           stream_done = 1'b0;
    logic [127:0] cur_s;
    logic [127:0] rt_q [$];

    always @(negedge clk) begin
        if (streaming && !rst) begin
            if (bus1.out_valid && bus1.out_ready && rt_q.size() > 0) begin
                check("roundtrip", bus1.out_data, rt_q.pop_front());
            end
            if (bus1.in_valid && bus1.in_ready) rt_q.push_back(cur_s);
        end
    end

    // All tasks start and return at 1 ns after a rising edge.
    task automatic send(input logic [127:0] d);
        int n = 0;
        bus1.in_data  = d;
        bus1.in_valid = 1'b1;
        @(negedge clk);
        while (!bus1.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_timeout", 128'(n < 50), 128'(1));
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus1.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, 128'(n < 20), 128'(1));
    endtask

    task automatic run_block(input string name, input logic [127:0] d, input logic [127:0] exp);
        bus1.out_ready = 1'b1;
        send(d);
        wait_valid({name, "_timeout"});
        check(name, bus1.out_data, exp);
        @(posedge clk); #1;
    endtask

    task automatic run_wide(input logic [127:0] d, input logic [127:0] exp);
        int lat2 = -1;
        int lat4 = -1;
        bus2.in_data  = d;
        bus4.in_data  = d;
        bus2.in_valid = 1'b1;
        bus4.in_valid = 1'b1;
        @(negedge clk);
        check("wide2_in_ready", 128'(bus2.in_ready), 128'(1));
        check("wide4_in_ready", 128'(bus4.in_ready), 128'(1));
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (bus2.out_valid && lat2 < 0) begin
                lat2 = k;
                check("wide2_data", bus2.out_data, exp);
            end
            if (bus4.out_valid && lat4 < 0) begin
                lat4 = k;
                check("wide4_data", bus4.out_data, exp);
            end
        end
        check_i("wide2_latency", lat2, 2);
        check_i("wide4_latency", lat4, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] FIPS_IN  [3] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h4d7ebdf8};
    localparam logic [31:0] FIPS_OUT [3] = '{32'hdb135345, 32'hf20a225c, 32'h2d26314c};

    logic [127:0] mixed_in, mixed_out, va, vb, s;
    logic [31:0]  fi, fo;
    int           n;

    initial begin
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b1;
        mixed_in  = {32'h8e4da1bc, 32'h9fdc589d, 32'h4d7ebdf8, 32'h01010101};
        mixed_out = {32'hdb135345, 32'hf20a225c, 32'h2d26314c, 32'h01010101};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", 128'(bus1.in_ready), 128'(1));
        @(posedge clk); #1;

        // Pin the model to hand-computed vectors.
        for (int i = 0; i < 3; i++) begin
            fi = FIPS_IN[i];
            fo = FIPS_OUT[i];
            check("model_fips", mix({4{fi}}, 1'b1), {4{fo}});
        end
        check("model_mixed", mix(mixed_in, 1'b1), mixed_out);
        check("model_fwd_fips", mix({4{32'hdb135345}}, 1'b0), {4{32'h8e4da1bc}});

        for (int i = 0; i < 3; i++) begin
            fi = FIPS_IN[i];
            fo = FIPS_OUT[i];
            run_block("fips_vector", {4{fi}}, {4{fo}});
        end
        run_block("identity_01", {4{32'h01010101}}, {4{32'h01010101}});
        run_block("identity_c6", {4{32'hc6c6c6c6}}, {4{32'hc6c6c6c6}});
        run_block("mixed_w1", mixed_in, mixed_out);
        run_wide(mixed_in, mixed_out);

        // Backpressure: result held, new block refused until the output is taken.
        va = {$urandom(), $urandom(), $urandom(), $urandom()};
        vb = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus1.out_ready = 1'b0;
        send(va);
        wait_valid("bp_valid_timeout");
        @(posedge clk); #1;
        bus1.in_data  = vb;
        bus1.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_data", bus1.out_data, mix(va, 1'b1));
            check("bp_in_ready", 128'(bus1.in_ready), 128'(0));
        end
        @(posedge clk); #1;
        bus1.out_ready = 1'b1;
        @(negedge clk);
        check("bp_swap_ready", 128'(bus1.in_ready), 128'(1));
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        wait_valid("bp_second_timeout");
        check("bp_second", bus1.out_data, mix(vb, 1'b1));
        @(posedge clk); #1;

        // Reset while BUSY with cnt=2.
        send(va);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy_in_ready", 128'(bus1.in_ready), 128'(1));
        check("rst_busy_out_data", bus1.out_data, 128'(0));
        @(posedge clk); #1;
        run_block("after_rst_busy", {4{32'h9fdc589d}}, {4{32'hf20a225c}});

        // Reset while DONE with the result pending.
        bus1.out_ready = 1'b0;
        send(vb);
        wait_valid("rst_done_valid_timeout");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_done_in_ready", 128'(bus1.in_ready), 128'(1));
        check("rst_done_out_valid", 128'(bus1.out_valid), 128'(0));
        @(posedge clk); #1;
        run_block("after_rst_done", {4{32'h4d7ebdf8}}, {4{32'h2d26314c}});

        // Random round-trip stream with random in_valid gaps and out_ready stalls.
        streaming = 1'b1;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    s = {$urandom(), $urandom(), $urandom(), $urandom()};
                    while ($urandom_range(0, 3) == 0) begin
                        bus1.in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    cur_s         = s;
                    bus1.in_data  = mix(s, 1'b0);
                    bus1.in_valid = 1'b1;
                    n = 0;
                    @(negedge clk);
                    while (!bus1.in_ready && n < 50) begin
                        @(negedge clk);
                        n++;
                    end
                    if (n >= 50) check_i("stream_accept_timeout", n, 0);
                    @(posedge clk); #1;
                end
                bus1.in_valid = 1'b0;
                n = 0;
                while ((rt_q.size() != 0 || bus1.out_valid) && n < 200) begin
                    @(posedge clk); #1;
                    n++;
                end
                check("stream_drain", 128'(n < 200), 128'(1));
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk); #1;
                    bus1.out_ready = 1'($urandom_range(0, 1));
                end
                bus1.out_ready = 1'b1;
            end
        join
        streaming = 1'b0;

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
